// File: rtl/multicycle_ctrl.sv
// Multicycle processor main controller: Moore FSM sequencing fetch, decode and
// execute phases, producing datapath mux selects and pre-conditioned write strobes.
module multicycle_ctrl (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic [1:0] FlagW,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] State
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXECR  = 4'd6;
    localparam logic [3:0] EXECI  = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;

    logic [3:0] state;
    logic [3:0] state_next;
    logic [3:0] cmd;
    logic       alu_state;
    logic       flag_state;
    logic       pc_dest;

    assign cmd        = Funct[4:1];
    assign alu_state  = (state == EXECR) || (state == EXECI) || (state == ALUWB);
    assign flag_state = (state == EXECR) || (state == EXECI);
    assign pc_dest    = (Rd == 4'd15);
    assign State      = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = MemReady ? MEMWB : MEMRD;
            MEMWB:  state_next = FETCH;
            MEMWR:  state_next = MemReady ? FETCH : MEMWR;
            EXECR:  state_next = ALUWB;
            EXECI:  state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        NoWrite    = 1'b0;
        FlagW      = 2'b00;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;

        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                NextPC    = MemReady;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                PCS       = pc_dest;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECI: ALUSrcB = 2'b01;
            ALUWB: begin
                RegW    = 1'b1;
                PCS     = pc_dest;
                NoWrite = (cmd == 4'b1010);
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCS       = 1'b1;
            end
            default: ;
        endcase

        if (alu_state) begin
            case (cmd)
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b1010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                default: ALUControl = 2'b00;
            endcase
        end

        // C/V flags are only meaningful for arithmetic (ADD, SUB, CMP)
        if (flag_state && Funct[0]) begin
            FlagW[1] = 1'b1;
            FlagW[0] = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        end

        if (RESET) begin
            PCS     = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            NoWrite = 1'b0;
            FlagW   = 2'b00;
            IRWrite = 1'b0;
            NextPC  = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Op, input, 2 bits: instruction class from IR (00 DP, 01 MEM, 10 B, 11 undefined).
REQ-004 SHALL have port Funct, input, 6 bits: IR[25:20] (I, cmd[3:0], S/L).
REQ-005 SHALL have port Rd, input, 4 bits: destination register field.
REQ-006 SHALL have port MemReady, input, 1 bit: memory completes access this cycle.
REQ-007 SHALL have ports PCS, RegW, MemW, NoWrite, output, 1 bit each; and FlagW, output, 2 bits. These are the CondLogic pre-conditioned strobes.
REQ-008 SHALL have ports IRWrite, NextPC, AdrSrc, ALUSrcA, output, 1 bit each.
REQ-009 SHALL have ports ALUSrcB, ResultSrc, ALUControl, output, 2 bits each; and State, output, 4 bits (debug).

Function
REQ-010 SHALL implement a Moore FSM with 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-011 Transitions SHALL be as follows. FETCH->DECODE only when MemReady=1, else hold. DECODE->MEMADR when Op=01. DECODE->EXECR when Op=00 and Funct[5]=0. DECODE->EXECI when Op=00 and Funct[5]=1. DECODE->BRANCH when Op=10. DECODE->FETCH when Op=11.
REQ-012 Further transitions SHALL be as follows. MEMADR->MEMRD if Funct[0]=1, else MEMWR. MEMRD->MEMWB only when MemReady=1, else hold. MEMWB->FETCH. MEMWR->FETCH only when MemReady=1, else hold. EXECR/EXECI->ALUWB. ALUWB->FETCH. BRANCH->FETCH.
REQ-013 In FETCH the block SHALL drive AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite and NextPC SHALL be 1 only in the FETCH cycle where MemReady=1.
REQ-014 In DECODE the block SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10. In MEMADR and BRANCH it SHALL drive ALUSrcA=0, ALUSrcB=01. In EXECR it SHALL drive ALUSrcA=0, ALUSrcB=00. In EXECI it SHALL drive ALUSrcA=0, ALUSrcB=01.
REQ-015 In MEMRD the block SHALL drive AdrSrc=1, ResultSrc=00. In MEMWR it SHALL drive AdrSrc=1, ResultSrc=00, and MemW=1 for every cycle in the state, including wait cycles. In MEMWB it SHALL drive ResultSrc=01, RegW=1. In ALUWB it SHALL drive ResultSrc=00, RegW=1. In BRANCH it SHALL drive ResultSrc=10.
REQ-016 Any output not listed for a state SHALL be 0.
REQ-017 ALUControl SHALL be 00 (ADD) outside EXECR/EXECI/ALUWB. Inside those states it SHALL decode Funct[4:1] as: 0100->00, 0010->01, 1010 (CMP)->01, 0000->10, 1100->11; any other value ->00.
REQ-018 FlagW SHALL be nonzero only in EXECR/EXECI with Funct[0]=1: FlagW[1]=1, and FlagW[0]=1 iff Funct[4:1] is 0100, 0010 or 1010.
REQ-019 NoWrite SHALL be 1 only in ALUWB with Funct[4:1]=1010; RegW SHALL remain 1 in that cycle, and gating is left to CondLogic.
REQ-020 PCS SHALL equal 1 in BRANCH, and in MEMWB or ALUWB when Rd=15; otherwise 0.
REQ-021 Op, Funct and Rd SHALL be sampled combinationally each cycle; the block stores no IR copy.
REQ-022 Latency at MemReady=1 SHALL be: DP 4 cycles, LDR 5, STR 4, B 3, undefined 2. Each wait cycle SHALL add 1.

Reset
REQ-023 While RESET=1 at a rising edge, State SHALL become FETCH, irrespective of current state or MemReady.
REQ-024 During any cycle with RESET=1, IRWrite, NextPC, RegW, MemW, PCS, FlagW and NoWrite SHALL be forced to 0.
REQ-025 After RESET deasserts, the first cycle SHALL be FETCH, with all mux selects at FETCH values.
REQ-026 Reset asserted mid-instruction (e.g. in MEMWR waiting) SHALL abort it with no further MemW/RegW pulse.

Verification
REQ-027 ADD reg (Op=00, Funct=001000, Rd=3, MemReady=1) -> States 0,1,6,8,0. RegW=1 only at state 8. PCS=0, FlagW=00.
REQ-028 LDR (Op=01, Funct=011001) with MemReady=0 for 2 cycles in MEMRD -> States 0,1,2,3,3,3,4,0. RegW=1 only at state 4.
REQ-029 CMP imm (Op=00, Funct=110101) -> FlagW=11 in EXECI. ALUControl=01. NoWrite=1 and RegW=1 in ALUWB.
REQ-030 B (Op=10) -> States 0,1,9,0. PCS=1, ALUSrcB=01 only in state 9. ORR with S=1, Rd=15 -> FlagW=10, PCS=1 in ALUWB.
REQ-031 STR (Op=01, Funct=011000), MemReady=0 in MEMWR, with RESET pulsed for 1 cycle -> MemW=0 during reset cycle. Next state 0, IRWrite=0 until MemReady=1.
REQ-032 FETCH with MemReady=0 for 3 cycles -> State stays 0. IRWrite=NextPC=0 until the MemReady=1 cycle, then both are 1 for exactly 1 cycle.
